bus_reg_responder: RTL
======================

Name: bus_reg_responder

Overview:
- Responder end of the MCU data bus driven by the execute stage.
- Decodes bus_rd_en/bus_wr_en requests against a local bank of 10-bit registers and returns read data after a fixed pipeline latency.
- Forwards accepted writes through a small write FIFO to a downstream peripheral port with a valid/ready handshake.
- Asserts bus_busy so the core can stall the PC while the FIFO is full.

Parameters:
- NUM_REGS, 16, number of 10-bit registers at bus addresses 0..NUM_REGS-1; must be <= ADDR_BOUNDRY.
- ADDR_BOUNDRY, 8'h40, addresses >= this value belong to internal space and are ignored by this block.
- RD_LATENCY, 1, cycles from bus_rd_en to bus_rd_valid; legal range 1..4.
- WFIFO_DEPTH, 4, write FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_rd_en  input  1  read request, one cycle per read.
- bus_rd_addr  input  8  read address.
- bus_rd_data  output  10  read data; valid when bus_rd_valid is high.
- bus_rd_valid  output  1  one-cycle pulse, RD_LATENCY cycles after bus_rd_en.
- bus_wr_en  input  1  write request.
- bus_wr_addr  input  8  write address.
- bus_wr_data  input  10  write data.
- bus_busy  output  1  write FIFO full.
- addr_err  output  1  one-cycle pulse on access to NUM_REGS <= addr < ADDR_BOUNDRY.
- wr_ovf  output  1  sticky flag: a write was dropped because the FIFO was full.
- periph_wr_valid  output  1  FIFO head valid.
- periph_wr_addr  output  8  FIFO head address.
- periph_wr_data  output  10  FIFO head data.
- periph_wr_ready  input  1  peripheral accepts the head this cycle.

Behaviour:
- Reset (clk edge with rst=1):
  - All registers, FIFO pointers and count, and the read pipeline clear to 0.
  - All outputs 0: bus_rd_data, bus_rd_valid, bus_busy, addr_err, wr_ovf, periph_wr_*.
  - Reset mid-operation discards in-flight reads and queued writes with no further pulses.
- Address classes:
  - A ≡ addr < NUM_REGS: accepted.
  - E ≡ NUM_REGS <= addr < ADDR_BOUNDRY: error.
  - I ≡ addr >= ADDR_BOUNDRY: ignored silently, no pulse, no state change.
- Reads:
  - bus_rd_en sampled at edge N enters a shift pipeline of depth RD_LATENCY.
  - Data is captured from the register bank at edge N.
  - bus_rd_valid is high for exactly the cycle after edge N+RD_LATENCY-1.
  - Class E or I reads still pulse valid, with data 10'd0.
  - Back-to-back reads are allowed every cycle, with no bubbles.
  - bus_rd_data holds its last value between pulses.
- Read-before-write: a read and a write to the same address on the same edge return the OLD value.
- Writes (class A, FIFO not full):
  - The register bank updates at the same edge.
  - {addr, data} is pushed to the FIFO.
- Writes when full:
  - Class A with count==WFIFO_DEPTH at the edge: bank NOT updated, no push, wr_ovf set.
  - A push is refused when full even if a pop occurs on the same edge, because full is decided on the registered count.
- Class E writes: pulse addr_err, no bank or FIFO change.
- Reads and writes may be active on the same cycle; they are independent.
- Error pulses: addr_err pulses the cycle after the offending edge. A read error and a write error on the same edge produce a single pulse.
- FIFO:
  - Circular buffer with log2(WFIFO_DEPTH)-bit pointers that wrap, plus a count register.
  - periph_wr_* presents the head combinationally from the FIFO storage; it is registered state, not a bypass.
  - A pop happens on an edge with periph_wr_valid && periph_wr_ready.
  - Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - Push into an empty FIFO: periph_wr_valid rises the cycle after the push edge (no same-cycle bypass).
  - periph_wr_addr/data are stable while valid && !ready.
- bus_busy = (count == WFIFO_DEPTH), registered-count based.
- wr_ovf stays set until rst.

Test Plan:
- Reset, then write addr 3 data 10'h155; read addr 3 (RD_LATENCY=1) -> bus_rd_valid pulses 1 cycle later with 10'h155; periph_wr_valid=1, addr 3, data 10'h155; hold periph_wr_ready=1 -> FIFO empties, valid drops.
- Hold periph_wr_ready=0; write addrs 0..3 data 1..4 -> bus_busy=1 after the 4th. Write addr 5 data 9 -> dropped, wr_ovf=1, a read of addr 5 returns 0. Release ready -> periph sees (0,1),(1,2),(2,3),(3,4) in order, bus_busy falls after the first pop.
- FIFO full plus push and pop on the same edge -> push refused, count goes to 3, wr_ovf set.
- Read addr 20 (NUM_REGS=16) -> valid pulse, data 0, addr_err pulse. Write addr 8'h50 -> no addr_err, no FIFO push, bank unchanged.
- RD_LATENCY=3, reads of addrs 0,1,2 on consecutive cycles -> three consecutive valid pulses starting 3 cycles after the first read, carrying the correct data. A same-edge write to addr 1 with 10'h3FF is returned as the old value.
- Assert rst with 2 entries queued and a read in flight -> next cycle all outputs 0, no bus_rd_valid pulse, periph_wr_valid=0.

Source files
------------

// File: rtl/bus_reg_responder.sv
// Bus responder: 10-bit register bank, reads return after RD_LATENCY cycles, accepted writes queue to a peripheral port.
// Backpressure: bus_busy while the write FIFO is full; a write arriving then is dropped and flagged in sticky wr_ovf.
module bus_reg_responder #(
  parameter int         NUM_REGS     = 16,
  parameter logic [7:0] ADDR_BOUNDRY = 8'h40,
  parameter int         RD_LATENCY   = 1,
  parameter int         WFIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_rd_en,
  input  logic [7:0] bus_rd_addr,
  output logic [9:0] bus_rd_data,
  output logic       bus_rd_valid,
  input  logic       bus_wr_en,
  input  logic [7:0] bus_wr_addr,
  input  logic [9:0] bus_wr_data,
  output logic       bus_busy,
  output logic       addr_err,
  output logic       wr_ovf,
  output logic       periph_wr_valid,
  output logic [7:0] periph_wr_addr,
  output logic [9:0] periph_wr_data,
  input  logic       periph_wr_ready
);

  localparam int              RIW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int              PW    = $clog2(WFIFO_DEPTH);
  localparam int              CW    = PW + 1;
  localparam logic [7:0]      NREG  = 8'(NUM_REGS);
  localparam logic [CW-1:0]   DEPTH = CW'(WFIFO_DEPTH);

  typedef struct packed {
    logic [7:0] addr;
    logic [9:0] data;
  } wentry_t;

  logic [9:0]            bank [NUM_REGS];
  wentry_t               fifo_mem [WFIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [RD_LATENCY-1:0] rd_vpipe;
  logic [9:0]            rd_dpipe [RD_LATENCY];

  logic       rd_cls_a, rd_cls_e, wr_cls_a, wr_cls_e;
  logic       full, push, pop;
  logic [9:0] rd_word;

  always_comb begin
    rd_cls_a = (bus_rd_addr < NREG);
    rd_cls_e = !rd_cls_a && (bus_rd_addr < ADDR_BOUNDRY);
    wr_cls_a = (bus_wr_addr < NREG);
    wr_cls_e = !wr_cls_a && (bus_wr_addr < ADDR_BOUNDRY);
    // Full is judged on the registered count, so a same-edge pop never frees room for a push.
    full     = (count == DEPTH);
    push     = bus_wr_en && wr_cls_a && !full;
    pop      = periph_wr_valid && periph_wr_ready;
    rd_word  = rd_cls_a ? bank[bus_rd_addr[RIW-1:0]] : 10'd0;
  end

  assign periph_wr_valid = (count != '0);
  assign periph_wr_addr  = fifo_mem[rd_ptr].addr;
  assign periph_wr_data  = fifo_mem[rd_ptr].data;
  assign bus_busy        = full;
  assign bus_rd_valid    = rd_vpipe[RD_LATENCY-1];
  assign bus_rd_data     = rd_dpipe[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)    bank[i]     <= '0;
      for (int i = 0; i < WFIFO_DEPTH; i++) fifo_mem[i] <= '0;
      for (int i = 0; i < RD_LATENCY; i++)  rd_dpipe[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_vpipe <= '0;
      addr_err <= 1'b0;
      wr_ovf   <= 1'b0;
    end else begin
      if (push) begin
        bank[bus_wr_addr[RIW-1:0]] <= bus_wr_data;
        fifo_mem[wr_ptr]           <= '{addr: bus_wr_addr, data: bus_wr_data};
        wr_ptr                     <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus_wr_en && wr_cls_a && full)
        wr_ovf <= 1'b1;
      addr_err <= (bus_rd_en && rd_cls_e) || (bus_wr_en && wr_cls_e);

      // Data stages only advance behind a valid, so the last stage holds between pulses.
      rd_vpipe[0] <= bus_rd_en;
      if (bus_rd_en)
        rd_dpipe[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vpipe[i] <= rd_vpipe[i-1];
        if (rd_vpipe[i-1])
          rd_dpipe[i] <= rd_dpipe[i-1];
      end
    end
  end

endmodule
